// File: rtl/mem_block_dma_pkg.sv
// Shared block-memory bus package: bus widths and DMA state encoding,
// also used by the data cache and data-memory blocks.
package mem_bus_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    GAP  = 3'd3,
    FIN  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/mem_block_dma_req_tracker.sv
// Request completion tracker for one READ or WRITE request on the block bus.
// The first cycle of a request never completes; memory raises BUSYWAIT combinationally.
module mem_req_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic busywait,
  output logic req_done
);

  logic held_r;

  assign req_done = req & held_r & ~busywait;

  // Marks a request that has been presented for at least one full cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r <= 1'b0;
    end else if (req && !req_done) begin
      held_r <= 1'b1;
    end else begin
      held_r <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_block_dma.sv
// mem_block_dma: block-copy initiator on the READ/WRITE/BUSYWAIT block memory bus.
// Define MEM_BLOCK_DMA_REVERSE_COPY_EN for memmove-correct descending copies on forward overlap.
module mem_block_dma #(
  parameter int ADDR_W = mem_bus_pkg::ADDR_W,
  parameter int DATA_W = mem_bus_pkg::DATA_W,
  parameter int LEN_W  = mem_bus_pkg::LEN_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [ADDR_W-1:0] DST_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  import mem_bus_pkg::*;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  dma_state_e        state_r;
  logic [ADDR_W-1:0] src_ptr_r;
  logic [ADDR_W-1:0] dst_ptr_r;
  logic [LEN_W-1:0]  remaining_r;
  logic [DATA_W-1:0] buf_r;
  logic              busy_r;
  logic              done_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [ADDR_W-1:0] mem_address_r;

  logic              req_done_s;
  logic [LEN_W-1:0]  len_clamped_s;
  logic [ADDR_W-1:0] src_start_s;
  logic [ADDR_W-1:0] dst_start_s;
  logic [ADDR_W-1:0] src_next_s;
  logic [ADDR_W-1:0] dst_next_s;

`ifdef MEM_BLOCK_DMA_REVERSE_COPY_EN
  logic [LEN_W:0]    src_end_s;
  logic [ADDR_W-1:0] ofs_s;
  logic              down_s;
  logic              down_r;
`endif

  assign BUSY          = busy_r;
  assign DONE          = done_r;
  assign MEM_READ      = mem_read_r;
  assign MEM_WRITE     = mem_write_r;
  assign MEM_ADDRESS   = mem_address_r;
  assign MEM_WRITEDATA = buf_r;

  mem_req_tracker u_req_tracker (
    .clk      (CLK),
    .rst_n    (RESET),
    .req      (mem_read_r | mem_write_r),
    .busywait (MEM_BUSYWAIT),
    .req_done (req_done_s)
  );

  // Length clamp, start pointers and per-block pointer steps.
  always_comb begin
    len_clamped_s = (LEN > MAX_LEN) ? MAX_LEN : LEN;
`ifdef MEM_BLOCK_DMA_REVERSE_COPY_EN
    // Forward overlap (dst inside (src, src+len)) is copied from the top block down.
    src_end_s   = (LEN_W+1)'(SRC_ADDR) + (LEN_W+1)'(len_clamped_s);
    ofs_s       = ADDR_W'(len_clamped_s - LEN_W'(1));
    down_s      = (DST_ADDR > SRC_ADDR) && ((LEN_W+1)'(DST_ADDR) < src_end_s);
    src_start_s = down_s ? (SRC_ADDR + ofs_s) : SRC_ADDR;
    dst_start_s = down_s ? (DST_ADDR + ofs_s) : DST_ADDR;
    src_next_s  = down_r ? (src_ptr_r - ADDR_W'(1)) : (src_ptr_r + ADDR_W'(1));
    dst_next_s  = down_r ? (dst_ptr_r - ADDR_W'(1)) : (dst_ptr_r + ADDR_W'(1));
`else
    src_start_s = SRC_ADDR;
    dst_start_s = DST_ADDR;
    src_next_s  = src_ptr_r + ADDR_W'(1);
    dst_next_s  = dst_ptr_r + ADDR_W'(1);
`endif
  end

  // Copy sequencer with registered bus and status outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r       <= IDLE;
      src_ptr_r     <= '0;
      dst_ptr_r     <= '0;
      remaining_r   <= '0;
      buf_r         <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_address_r <= '0;
`ifdef MEM_BLOCK_DMA_REVERSE_COPY_EN
      down_r        <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (START) begin
            src_ptr_r   <= src_start_s;
            dst_ptr_r   <= dst_start_s;
            remaining_r <= len_clamped_s;
`ifdef MEM_BLOCK_DMA_REVERSE_COPY_EN
            down_r      <= down_s;
`endif
            if (len_clamped_s == LEN_W'(0)) begin
              state_r <= FIN;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r       <= RD;
              busy_r        <= 1'b1;
              mem_read_r    <= 1'b1;
              mem_address_r <= src_start_s;
            end
          end
        end
        RD: begin
          if (req_done_s) begin
            buf_r         <= MEM_READDATA;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b1;
            mem_address_r <= dst_ptr_r;
            state_r       <= WR;
          end
        end
        WR: begin
          if (req_done_s) begin
            mem_write_r <= 1'b0;
            src_ptr_r   <= src_next_s;
            dst_ptr_r   <= dst_next_s;
            remaining_r <= remaining_r - LEN_W'(1);
            if (remaining_r == LEN_W'(1)) begin
              state_r <= FIN;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r <= GAP;
            end
          end
        end
        GAP: begin
          // Both requests were low for one cycle; memory now sees a fresh edge.
          state_r       <= RD;
          mem_read_r    <= 1'b1;
          mem_address_r <= src_ptr_r;
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_block_dma.md
Name: mem_block_dma

Overview:
- Block-copy engine acting as an **initiator** on the block-level memory bus used between the data cache and data memory.
- Bus shape: READ/WRITE/BUSYWAIT handshake, 6-bit block address, 32-bit block data.
- Given a source block, a destination block and a block count, it reads each block from memory and writes it to the destination, one block at a time.
- Sits beside the data cache as a second master on the data-memory port (muxing is external). Used for memory preload/relocation and as a protocol exerciser for the memory responder.

Parameters:
- ADDR_W, 6, block address width (64 blocks).
- DATA_W, 32, block data width.
- LEN_W, 7, length field width; legal lengths are 0..64.

Ports:
- CLK  input  1  system clock, all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- START  input  1  one-cycle command strobe; sampled only in IDLE.
- SRC_ADDR  input  ADDR_W  first source block address; captured on START.
- DST_ADDR  input  ADDR_W  first destination block address; captured on START.
- LEN  input  LEN_W  number of blocks to copy; captured on START.
- BUSY  output  1  high from the cycle after an accepted START until DONE.
- DONE  output  1  one-cycle pulse when the copy completes.
- MEM_READ  output  1  block read request.
- MEM_WRITE  output  1  block write request.
- MEM_ADDRESS  output  ADDR_W  block address of current request.
- MEM_WRITEDATA  output  DATA_W  block data for writes.
- MEM_READDATA  input  DATA_W  block data returned by memory.
- MEM_BUSYWAIT  input  1  memory busy; request completes when it is low.

Behaviour:
- Reset (RESET=0, async):
  - State=IDLE.
  - BUSY, DONE, MEM_READ and MEM_WRITE are 0.
  - MEM_ADDRESS, MEM_WRITEDATA, the data buffer and all counters are 0.
  - Reset mid-transfer aborts immediately. No DONE is issued. A partially written destination is left as is.
- States: IDLE, RD, WR, GAP, FIN.
- IDLE:
  - On START=1 at posedge, capture src/dst/len.
  - len=0 → FIN. Otherwise → RD with BUSY=1.
  - START while not IDLE is ignored.
- RD:
  - MEM_READ=1, MEM_ADDRESS=src_ptr.
  - The request is complete at a posedge where MEM_BUSYWAIT=0 and RD has been held at least one full cycle. The first cycle of a request never completes, because memory raises BUSYWAIT combinationally.
  - On completion, latch MEM_READDATA into the buffer → WR.
- WR:
  - MEM_WRITE=1, MEM_ADDRESS=dst_ptr, MEM_WRITEDATA=buffer. Same completion rule as RD.
  - On completion: src_ptr+=1, dst_ptr+=1, remaining-=1.
  - remaining becomes 0 → FIN; else → GAP.
- GAP:
  - One cycle with MEM_READ=MEM_WRITE=0, so the memory sees a fresh request edge.
  - → RD.
- FIN:
  - DONE=1 for exactly one cycle, BUSY=0.
  - → IDLE. A START on the cycle after FIN is accepted.
- MEM_READ and MEM_WRITE are never high simultaneously.
- Address and writedata are stable for the entire life of a request.
- Pointer arithmetic is modulo 2^ADDR_W: address 63+1 wraps to 0.
- LEN>64 is clamped to 64.
- Overlapping ranges are copied in ascending order only; the forward-overlap result is undefined unless REVERSE_COPY_EN is set.
- Worst-case cycles per block = 2×(memory latency) + 1 GAP.

Optional Feature:
- Macro: MEM_BLOCK_DMA_REVERSE_COPY_EN.
- Defined:
  - At START, if dst > src and dst < src+len (modulo, non-wrapping case), both pointers start at base+len-1 and decrement.
  - This gives memmove-correct overlapping copies.
  - DONE timing is unchanged.
- Undefined: always ascending, and the direction logic is absent.

Decomposition:
- Shared package (mem_bus_pkg): ADDR_W/DATA_W constants and the state encoding enum (IDLE, RD, WR, GAP, FIN).
- The same package serves dcache/data-memory users.
- One natural sub-module, mem_req_tracker:
  - Holds the "request held ≥1 cycle" flag.
  - Produces req_done from MEM_BUSYWAIT.
  - Reused for the RD and WR phases.

Test Plan:
- Single block: mem[5]=32'hDEADBEEF; START src=5 dst=20 len=1.
  - One read at addr 5, then one write at addr 20 with data DEADBEEF.
  - DONE pulses once; mem[20]=DEADBEEF; BUSY low after DONE.
- Multi-block with wrap: mem[62]=A, mem[63]=B, mem[0]=C; START src=62 dst=10 len=3.
  - Reads 62, 63, 0 in order; mem[10..12]=A,B,C.
  - Exactly one GAP cycle with both requests low between blocks.
- Zero length: START len=0.
  - No MEM_READ/MEM_WRITE ever asserted; DONE on the 2nd posedge after START.
- Handshake timing: memory holding BUSYWAIT for 5 cycles.
  - MEM_ADDRESS/MEM_WRITEDATA constant throughout, and no completion on the first request cycle.
  - A START pulsed while BUSY is ignored (no second DONE).
- Reset mid-copy: len=8, RESET=0 during the WR of block 3.
  - Outputs go to 0 asynchronously in the same cycle; no DONE.
  - A subsequent len=1 copy works normally.
- REVERSE_COPY_EN: mem[0..3]=1,2,3,4; START src=0 dst=1 len=4.
  - Macro defined: mem[1..4]=1,2,3,4.
  - Macro undefined: the bench only checks that write addresses ascend.
